// File: rtl/layer_mac_sequencer.sv
// Layer MAC sequencer: streams shared weight/IO RAM read addresses, runs LANES signed Q7.8 MACs
// over N_IN activations plus a per-lane bias word, then saturates each lane to 16 bits.
//
// state   | meaning
// S_IDLE  | addresses 0, waiting for i_start (accumulators cleared on accept)
// S_FETCH | one read per clock, j = 0..N_IN (j == N_IN reads the bias word)
// S_DRAIN | RD_LAT clocks for the final read to return
// S_SAT   | register the saturated lane sums into o_result
// S_DONE  | o_done pulse, then back to S_IDLE
module layer_mac_sequencer #(
    parameter int LANES   = 20,
    parameter int N_IN    = 784,
    parameter int IN_BASE = 0,
    parameter int FRAC    = 8,
    parameter int RD_LAT  = 1,
    parameter int ACC_W   = 42
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [LANES*10-1:0]   o_w_address,
    input  logic [LANES*16-1:0]   i_w_q,
    output logic [9:0]            o_io_address,
    input  logic [15:0]           i_io_q,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [LANES*16-1:0]   o_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_SAT,
        S_DONE
    } state_t;

    localparam logic [9:0] LAST_J = 10'(N_IN);
    localparam logic [9:0] BASE   = 10'(IN_BASE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    state_t                   r_state;
    state_t                   w_next;
    logic [9:0]               r_j;
    logic [1:0]               r_drain;
    logic [RD_LAT-1:0]        r_vld;
    logic [RD_LAT-1:0]        r_last;
    logic signed [ACC_W-1:0]  r_acc [LANES];
    logic signed [ACC_W-1:0]  w_term [LANES];
    logic [LANES*16-1:0]      w_sat;
    logic [LANES*16-1:0]      r_result;
    logic [9:0]               w_addr;
    logic [9:0]               w_io_addr;
    logic                     w_accept;

    assign w_accept = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: if (r_j == LAST_J) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == 2'd0) w_next = S_SAT;
            S_SAT:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // r_drain is a down-counter loaded while fetching; DRAIN exits at terminal count 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_j     <= 10'd0;
            r_drain <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: r_j <= 10'd0;
                S_FETCH: begin
                    r_j     <= r_j + 10'd1;
                    r_drain <= 2'(RD_LAT - 1);
                end
                S_DRAIN: if (r_drain != 2'd0) r_drain <= r_drain - 2'd1;
                default: ;
            endcase
        end
    end

    // Valid/tag pipe lines up with the RAM latency so stage RD_LAT-1 marks the returning Q.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            r_vld[0]  <= (r_state == S_FETCH);
            r_last[0] <= (r_state == S_FETCH) && (r_j == LAST_J);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [15:0]      w_wq;
        logic signed [31:0]      w_prod;
        logic signed [ACC_W-1:0] w_shift;

        assign w_wq   = i_w_q[k*16 +: 16];
        assign w_prod = w_wq * $signed(i_io_q);
        // Bias is shifted up by FRAC so it shares the products' 2*FRAC fraction alignment.
        assign w_term[k] = r_last[RD_LAT-1]
                         ? {{(ACC_W-16-FRAC){w_wq[15]}}, w_wq, {FRAC{1'b0}}}
                         : {{(ACC_W-32){w_prod[31]}}, w_prod};
        assign w_shift = r_acc[k] >>> FRAC;
        assign w_sat[k*16 +: 16] = (w_shift > SAT_MAX) ? 16'h7FFF
                                 : (w_shift < SAT_MIN) ? 16'h8000
                                 : w_shift[15:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
        end else if (r_vld[RD_LAT-1]) begin
            for (int k = 0; k < LANES; k++) r_acc[k] <= r_acc[k] + w_term[k];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_result <= '0;
        end else if (r_state == S_SAT) begin
            r_result <= w_sat;
        end
    end

    // Addresses hold the bias word / base after the last read until the FSM returns to IDLE.
    always_comb begin
        w_addr    = 10'd0;
        w_io_addr = 10'd0;
        case (r_state)
            S_IDLE: ;
            S_FETCH: begin
                w_addr    = r_j;
                w_io_addr = (r_j == LAST_J) ? BASE : BASE + r_j;
            end
            default: begin
                w_addr    = LAST_J;
                w_io_addr = BASE;
            end
        endcase
    end

    assign o_w_address  = {LANES{w_addr}};
    assign o_io_address = w_io_addr;
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = (r_state == S_DONE);
    assign o_result     = r_result;

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Bench for layer_mac_sequencer: two instances (RD_LAT=1 and 2) share stimulus and RAM contents,
// a pass-level model predicts addresses/Busy/Done/Result every cycle, plus literal checks.
module tb_layer_mac_sequencer;

    localparam int LANES = 20;
    localparam int N_IN  = 4;
    localparam int FRAC  = 8;
    localparam int VW    = LANES * 16;

    logic clk = 1'b0;
    logic rst;
    logic start;

    always #5 clk = ~clk;

    logic signed [15:0] wmem [LANES][N_IN+1];
    logic signed [15:0] xmem [N_IN];

    logic [LANES*10-1:0] w_addr  [2];
    logic [VW-1:0]       wq      [2];
    logic [9:0]          io_addr [2];
    logic [15:0]         xq      [2];
    logic                busy    [2];
    logic                done    [2];
    logic [VW-1:0]       res     [2];

    int total = 0;
    int bad   = 0;

    function automatic logic signed [15:0] rdw(input int k, input logic [9:0] a);
        return wmem[k][(a <= 10'(N_IN)) ? int'(a) : 0];
    endfunction

    function automatic logic signed [15:0] rdx(input logic [9:0] a);
        return xmem[(a < 10'(N_IN)) ? int'(a) : 0];
    endfunction

    for (genvar u = 0; u < 2; u++) begin : g_u
        logic [VW-1:0] wp0, wp1;
        logic [15:0]   xp0, xp1;

        layer_mac_sequencer #(
            .LANES(LANES), .N_IN(N_IN), .IN_BASE(0), .FRAC(FRAC), .RD_LAT(u + 1), .ACC_W(42)
        ) dut (
            .i_clk(clk),
            .i_rst(rst),
            .i_start(start),
            .o_w_address(w_addr[u]),
            .i_w_q(wq[u]),
            .o_io_address(io_addr[u]),
            .i_io_q(xq[u]),
            .o_busy(busy[u]),
            .o_done(done[u]),
            .o_result(res[u])
        );

        always @(posedge clk) begin
            for (int k = 0; k < LANES; k++) wp0[k*16 +: 16] <= rdw(k, w_addr[u][k*10 +: 10]);
            xp0 <= rdx(io_addr[u]);
            wp1 <= wp0;
            xp1 <= xp0;
        end

        assign wq[u] = (u == 0) ? wp0 : wp1;
        assign xq[u] = (u == 0) ? xp0 : xp1;
    end

    function automatic logic [VW-1:0] rep(input logic [15:0] v);
        return {LANES{v}};
    endfunction

    // Expected lane sums straight from the arithmetic definition.
    function automatic logic [VW-1:0] calc();
        logic [VW-1:0] r;
        longint acc;
        longint s;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) acc += longint'(wmem[k][i]) * longint'(xmem[i]);
            acc += longint'(wmem[k][N_IN]) * (longint'(1) << FRAC);
            s = acc >>> FRAC;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[k*16 +: 16] = 16'(s);
        end
        return r;
    endfunction

    task automatic chk_v(input string nm, input int u, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d actual=%h required=%h", nm, u, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: m_t = clocks since the accepting edge (-1 when idle); Done sits at m_t == N_IN+RD_LAT+2.
    int            m_t   [2] = '{-1, -1};
    logic [VW-1:0] m_res [2] = '{'0, '0};
    logic [VW-1:0] m_pend[2];
    int            done_seen [2] = '{0, 0};

    initial forever begin
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            int d;
            d = N_IN + (u + 1) + 2;
            if (rst) begin
                m_t[u]   = -1;
                m_res[u] = '0;
            end else if (m_t[u] == d) begin
                m_t[u] = -1;
            end else if (m_t[u] >= 0) begin
                m_t[u]++;
                if (m_t[u] == d) m_res[u] = m_pend[u];
            end else if (start) begin
                m_t[u]    = 0;
                m_pend[u] = calc();
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        for (int u = 0; u < 2; u++) begin
            logic [9:0] ea;
            logic [9:0] eio;
            int d;
            d   = N_IN + (u + 1) + 2;
            ea  = (m_t[u] < 0) ? 10'd0 : (m_t[u] <= N_IN) ? 10'(m_t[u]) : 10'(N_IN);
            eio = (m_t[u] >= 0 && m_t[u] < N_IN) ? 10'(m_t[u]) : 10'd0;
            chk_v("w_address", u, VW'(w_addr[u]), VW'({LANES{ea}}));
            chk_v("io_address", u, VW'(io_addr[u]), VW'(eio));
            chk_v("busy", u, VW'(busy[u]), VW'(m_t[u] >= 0));
            chk_v("done", u, VW'(done[u]), VW'(m_t[u] == d));
            chk_v("result", u, res[u], m_res[u]);
            if (done[u]) done_seen[u]++;
        end
    end

    task automatic set_mem(input logic [15:0] wbase, input logic [15:0] wstep,
                           input logic [15:0] xval, input logic [15:0] bias);
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < N_IN; i++) wmem[k][i] = wbase + 16'(k) * wstep;
            wmem[k][N_IN] = bias;
        end
        for (int i = 0; i < N_IN; i++) xmem[i] = xval;
    endtask

    int         t_lat [2];
    int         t_reads;
    int         t_dones [2];
    logic [9:0] t_trace [16];

    // One pass from IDLE; optional extra Start pulse sampled at edge pulse_at.
    task automatic run_pass(input int pulse_at);
        int d0 [2];
        @(negedge clk);
        start = 1'b1;
        t_lat   = '{-1, -1};
        t_reads = 0;
        d0[0] = done_seen[0];
        d0[1] = done_seen[1];
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            t_trace[n] = w_addr[0][9:0];
            if (busy[0]) begin
                if (n == 0) t_reads++;
                else if (t_trace[n] != t_trace[n-1]) t_reads++;
            end
            for (int u = 0; u < 2; u++) if (done[u] && t_lat[u] < 0) t_lat[u] = n + 1;
            @(negedge clk);
            start = (n + 1 == pulse_at);
        end
        t_dones[0] = done_seen[0] - d0[0];
        t_dones[1] = done_seen[1] - d0[1];
    endtask

    logic [9:0] exp_tr [9] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd4, 10'd4, 10'd4, 10'd0};

    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        set_mem(16'h0100, 16'h0000, 16'h0100, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk_v("reset_result", u, res[u], '0);
            chk_v("reset_busy", u, VW'(busy[u]), '0);
            chk_v("reset_addr", u, VW'(w_addr[u]), '0);
        end

        // Test 1 plus address trace
        run_pass(-1);
        for (int u = 0; u < 2; u++) begin
            chk_i("t1_done_latency", t_lat[u], N_IN + (u + 1) + 3);
            chk_i("t1_single_done", t_dones[u], 1);
            chk_v("t1_result", u, res[u], rep(16'h0400));
        end
        for (int n = 0; n < 9; n++) chk_v("t4_trace", n, VW'(t_trace[n]), VW'(exp_tr[n]));
        chk_i("t4_distinct_reads", t_reads, N_IN + 1);

        // Test 2: per-lane weights, negative bias
        set_mem(16'h0000, 16'h0080, 16'h0200, 16'hFF00);
        run_pass(-1);
        for (int u = 0; u < 2; u++) begin
            chk_v("t2_lane0", u, VW'(res[u][15:0]), VW'(16'hFF00));
            chk_v("t2_lane19", u, VW'(res[u][19*16 +: 16]), VW'(16'h4B00));
        end

        // Test 3: saturation both signs
        set_mem(16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF);
        run_pass(-1);
        for (int u = 0; u < 2; u++) chk_v("t3_sat_pos", u, res[u], rep(16'h7FFF));
        set_mem(16'h8000, 16'h0000, 16'h7FFF, 16'h8000);
        run_pass(-1);
        for (int u = 0; u < 2; u++) chk_v("t3_sat_neg", u, res[u], rep(16'h8000));

        // Test 5: Start pulse during FETCH is ignored
        set_mem(16'h0100, 16'h0000, 16'h0100, 16'h0000);
        run_pass(2);
        for (int u = 0; u < 2; u++) begin
            chk_i("t5_single_done", t_dones[u], 1);
            chk_v("t5_result", u, res[u], rep(16'h0400));
        end

        // Test 5b: Start held high gives back-to-back passes every 9 clocks (RD_LAT=1)
        @(negedge clk);
        start = 1'b1;
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done[0]) begin
                cnt++;
                chk_v("t5_b2b_result", 0, res[0], rep(16'h0400));
            end
        end
        chk_i("t5_b2b_done_count", cnt, 3);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Test 6: reset at j=2 aborts the pass
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_v("t6_addr_before_rst", 0, VW'(w_addr[0][9:0]), VW'(10'd2));
        cnt = done_seen[0] + done_seen[1];
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk_v("t6_rst_result", u, res[u], '0);
            chk_v("t6_rst_busy", u, VW'(busy[u]), '0);
            chk_v("t6_rst_done", u, VW'(done[u]), '0);
            chk_v("t6_rst_addr", u, VW'(w_addr[u]), '0);
            chk_v("t6_rst_io_addr", u, VW'(io_addr[u]), '0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk_i("t6_no_done_after_abort", done_seen[0] + done_seen[1] - cnt, 0);
        run_pass(-1);
        for (int u = 0; u < 2; u++) begin
            chk_i("t6_done_after_restart", t_dones[u], 1);
            chk_v("t6_result", u, res[u], rep(16'h0400));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
